controle_multiciclo: RTL
========================

CONTROLE_MULTICICLO -- requirements
Module: controle_multiciclo

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port op, input, 6 bits: opcode field of the instruction register.
REQ-004 SHALL have port funct, input, 6 bits: funct field of the instruction register.
REQ-005 SHALL have port Z, input, 1 bit: zero flag from the ULA.
REQ-006 SHALL have port ULAcontrol, output, 3 bits: operation select to the ULA (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt).
REQ-007 SHALL have ports ir_write, reg_write, mem_write, iord, mem_to_reg, reg_dst, alu_src_a, output, 1 bit each: datapath enables and mux selects.
REQ-008 SHALL have ports alu_src_b and pc_src, output, 2 bits each: SrcB mux (00 reg, 01 const 4, 10 signext imm, 11 signext imm<<2) and PC mux (00 ULAresult, 01 ALUOut reg, 10 jump target).
REQ-009 SHALL have port pc_en, output, 1 bit: PC load enable, equal to pc_write OR (branch AND Z).
REQ-010 SHALL have port illegal, output, 1 bit: one-cycle pulse on an undecoded op/funct.
REQ-011 SHALL have ports state, output, 4 bits (current state, debug), and instr_count, output, 32 bits (retired instructions).

Function
REQ-012 SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 SHALL go to FETCH.
REQ-013 SHALL transition FETCH->DECODE unconditionally; DECODE on op: 100011/101011->MEMADR, 000000->EXEC, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP, other->FETCH with illegal=1.
REQ-014 SHALL transition MEMADR->MEMRD (lw) or MEMWR (sw), MEMRD->MEMWB, EXEC->ALUWB, ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
REQ-015 SHALL drive in FETCH: iord=0, ir_write=1, alu_src_a=0, alu_src_b=01, ULAcontrol=000, pc_src=00, pc_write=1.
REQ-016 SHALL drive in DECODE: alu_src_a=0, alu_src_b=11, ULAcontrol=000 (branch target precompute).
REQ-017 SHALL drive in MEMADR/ADDIEX: alu_src_a=1, alu_src_b=10, ULAcontrol=000; MEMRD: iord=1; MEMWR: iord=1, mem_write=1; MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; ALUWB: reg_write=1, reg_dst=1; ADDIWB: reg_write=1, reg_dst=0.
REQ-018 SHALL drive in EXEC: alu_src_a=1, alu_src_b=00, ULAcontrol from funct: 100000->000, 100010->001, 100100->010, 100101->011, 101010->101; other funct -> ULAcontrol=000, illegal=1, ALUWB skipped (EXEC->FETCH).
REQ-019 SHALL drive in BRANCH: alu_src_a=1, alu_src_b=00, ULAcontrol=001, pc_src=01, branch=1, so pc_en=Z; in JUMP: pc_src=10, pc_write=1.
REQ-020 SHALL hold every enable/select output not listed for a state at 0.
REQ-021 SHALL increment instr_count by 1 (wrapping 0xFFFFFFFF->0) on each transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB or JUMP; illegal-instruction returns SHALL NOT increment.

Reset
REQ-022 SHALL, on a rising clk edge with rst_n=0, set state=FETCH and instr_count=0, overriding any transition, including mid-instruction.
REQ-023 SHALL force ir_write, reg_write, mem_write, pc_en and illegal to 0 while rst_n=0, regardless of state.

Configuration
REQ-024 SHALL, with macro ULA_XOR_EN defined, decode funct 100110 in EXEC as ULAcontrol=100 followed by ALUWB.
REQ-025 SHALL, without ULA_XOR_EN, treat funct 100110 as illegal per REQ-018.

Verification
REQ-026 SHALL cover reset: rst_n=0 for 2 cycles from state=6 -> state=0, instr_count=0, pc_en=0 during reset.
REQ-027 SHALL cover lw: op=100011 -> states 0,1,2,3,4,0; mem_to_reg=1 and reg_write=1 only in state 4; instr_count+1.
REQ-028 SHALL cover beq: op=000100 with Z=1 -> pc_en=1 in BRANCH; with Z=0 -> pc_en=0; ULAcontrol=001 in both.
REQ-029 SHALL cover R-type slt: funct=101010 -> ULAcontrol=101 in EXEC, reg_dst=1 in ALUWB; 4 cycles total.
REQ-030 SHALL cover xor: funct=100110 -> ULAcontrol=100 with ULA_XOR_EN; illegal=1, EXEC->FETCH, instr_count unchanged without it.
REQ-031 SHALL cover illegal op=111111 -> illegal=1 for one cycle in DECODE, next state FETCH, instr_count unchanged.

Source files
------------

// File: rtl/controle_multiciclo_if.sv
// Control bundle between the multicycle controller and its datapath.
interface controle_multiciclo_if;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic        Z;
  logic [2:0]  ULAcontrol;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic        iord;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_src;
  logic        pc_en;
  logic        illegal;
  logic [3:0]  state;
  logic [31:0] instr_count;

  modport master (
    input  op, funct, Z,
    output ULAcontrol, ir_write, reg_write, mem_write, iord, mem_to_reg,
           reg_dst, alu_src_a, alu_src_b, pc_src, pc_en, illegal, state,
           instr_count
  );

  modport slave (
    output op, funct, Z,
    input  ULAcontrol, ir_write, reg_write, mem_write, iord, mem_to_reg,
           reg_dst, alu_src_a, alu_src_b, pc_src, pc_en, illegal, state,
           instr_count
  );
endinterface

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-style control FSM with retired-instruction counter.
// Define ULA_XOR_EN to decode R-type funct 100110 as xor.
module controle_multiciclo (
  input  logic                   clk,
  input  logic                   rst_n,
  controle_multiciclo_if.master  bus
);
  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6,  ALUWB  = 4'd7,
    BRANCH = 4'd8,  ADDIEX = 4'd9,  ADDIWB = 4'd10, JUMP   = 4'd11
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_count_q, instr_count_d;

  logic       ir_write, reg_write, mem_write, iord, mem_to_reg, reg_dst;
  logic       alu_src_a, pc_write, branch, illegal, pc_en, retire;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] ula_ctl;

  always_comb begin
    state_d    = FETCH;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    ula_ctl    = 3'b000;
    pc_write   = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    retire     = 1'b0;
    case (state_q)
      FETCH: begin
        ir_write  = 1'b1;
        alu_src_b = 2'b01;
        pc_write  = 1'b1;
        state_d   = DECODE;
      end
      DECODE: begin
        // ULA computes PC + (imm<<2) now so BRANCH can pick it up from ALUOut
        alu_src_b = 2'b11;
        case (bus.op)
          6'b100011, 6'b101011: state_d = MEMADR;
          6'b000000:            state_d = EXEC;
          6'b000100:            state_d = BRANCH;
          6'b001000:            state_d = ADDIEX;
          6'b000010:            state_d = JUMP;
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      MEMADR, ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (state_q == ADDIEX) state_d = ADDIWB;
        else                   state_d = (bus.op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        iord    = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
      end
      MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        retire    = 1'b1;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        state_d   = ALUWB;
        case (bus.funct)
          6'b100000: ula_ctl = 3'b000;
          6'b100010: ula_ctl = 3'b001;
          6'b100100: ula_ctl = 3'b010;
          6'b100101: ula_ctl = 3'b011;
          6'b101010: ula_ctl = 3'b101;
`ifdef ULA_XOR_EN
          6'b100110: ula_ctl = 3'b100;
`endif
          default: begin
            illegal = 1'b1;
            state_d = FETCH;
          end
        endcase
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        ula_ctl   = 3'b001;
        pc_src    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
      end
      default: state_d = FETCH;
    endcase

    pc_en = pc_write | (branch & bus.Z);

    // Write enables must be quiet for the whole reset, not just after the edge
    if (!rst_n) begin
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      pc_en     = 1'b0;
      illegal   = 1'b0;
    end

    instr_count_d = instr_count_q + {31'd0, retire};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      instr_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign bus.ULAcontrol  = ula_ctl;
  assign bus.ir_write    = ir_write;
  assign bus.reg_write   = reg_write;
  assign bus.mem_write   = mem_write;
  assign bus.iord        = iord;
  assign bus.mem_to_reg  = mem_to_reg;
  assign bus.reg_dst     = reg_dst;
  assign bus.alu_src_a   = alu_src_a;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.pc_src      = pc_src;
  assign bus.pc_en       = pc_en;
  assign bus.illegal     = illegal;
  assign bus.state       = state_q;
  assign bus.instr_count = instr_count_q;
endmodule
